enc_snap_ctrl: RTL

- Snapshot sequencer and channel-select arbiter for the shared encoder readback mux (the `reg_raddr_chan`-indexed quad/period/qtr1/qtr5/run outputs of the encoder controller).
- On a sample trigger it walks channels 1..NUM_CH and captures all five fields per channel into a double-buffered snapshot store.
- It shares the single channel-select bus with live host register reads. Host reads have priority; a starvation limit guarantees snapshot progress.

---
 rtl/enc_snap_ctrl_pkg.sv | 39 +++
 rtl/enc_snap_ctrl_if.sv | 30 +++
 rtl/enc_snap_bank.sv | 56 +++++
 rtl/enc_snap_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/enc_snap_ctrl_pkg.sv
// Shared constants and types for the encoder snapshot sequencer: channel
// counts, field codes, FSM encodings and the per-channel capture record.
package enc_snap_ctrl_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int CHAN_WIDTH   = 4;
  localparam int STARVE_LIMIT = 8;

  localparam logic [2:0] ENC_FLD_QUAD = 3'd0;
  localparam logic [2:0] ENC_FLD_PERD = 3'd1;
  localparam logic [2:0] ENC_FLD_QTR1 = 3'd2;
  localparam logic [2:0] ENC_FLD_QTR5 = 3'd3;
  localparam logic [2:0] ENC_FLD_RUN  = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [31:0] quad;
    logic [31:0] perd;
    logic [31:0] qtr1;
    logic [31:0] qtr5;
    logic [31:0] run;
  } enc_rec_t;

  // Field codes outside the five defined fields read as zero.
  function automatic logic [31:0] fld_sel(input enc_rec_t rec, input logic [2:0] fld);
    case (fld)
      ENC_FLD_QUAD: fld_sel = rec.quad;
      ENC_FLD_PERD: fld_sel = rec.perd;
      ENC_FLD_QTR1: fld_sel = rec.qtr1;
      ENC_FLD_QTR5: fld_sel = rec.qtr5;
      ENC_FLD_RUN:  fld_sel = rec.run;
      default:      fld_sel = '0;
    endcase
  endfunction

endpackage

// File: rtl/enc_snap_ctrl_if.sv
// Shared encoder readback bus: host live-read request/grant plus the
// channel-select mux and the five readback fields it returns.
interface enc_snap_ctrl_if #(
  parameter int CHAN_W = 4
);
  // host_rd_req is level: the host wants the mux in this cycle. host_rd_gnt
  // answers combinationally in the same cycle; the host may use the readback
  // fields only in cycles where req && gnt. No request is queued or remembered.
  logic              host_rd_req;
  logic [CHAN_W-1:0] host_rd_chan;
  logic              host_rd_gnt;
  logic [CHAN_W-1:0] enc_chan_sel;
  logic [31:0]       enc_quad;
  logic [31:0]       enc_perd;
  logic [31:0]       enc_qtr1;
  logic [31:0]       enc_qtr5;
  logic [31:0]       enc_run;

  modport master (
    output host_rd_req, host_rd_chan,
    output enc_quad, enc_perd, enc_qtr1, enc_qtr5, enc_run,
    input  host_rd_gnt, enc_chan_sel
  );

  modport slave (
    input  host_rd_req, host_rd_chan,
    input  enc_quad, enc_perd, enc_qtr1, enc_qtr5, enc_run,
    output host_rd_gnt, enc_chan_sel
  );
endinterface

// File: rtl/enc_snap_bank.sv
// Double-buffered snapshot store: captures go to the back bank, reads come
// from the front bank, and a swap exchanges them atomically.
module enc_snap_bank
  import enc_snap_ctrl_pkg::*;
#(
  parameter int NUM_CH = NUM_CHANNELS,
  parameter int CHAN_W = CHAN_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CHAN_W-1:0] wr_chan,
  input  enc_rec_t          wr_data,
  input  logic              swap,
  input  logic [CHAN_W-1:0] rd_chan,
  input  logic [2:0]        rd_field,
  output logic [31:0]       rd_data
);

  enc_rec_t mem [2][NUM_CH];
  logic     front;
  enc_rec_t rd_rec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          mem[b][c] <= '0;
        end
      end
    end else begin
      if (swap) begin
        front <= ~front;
      end
      // Channels are 1-based; entry c holds channel c+1.
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en && wr_chan == CHAN_W'(c + 1)) begin
          mem[~front][c] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    rd_rec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_chan == CHAN_W'(c + 1)) begin
        rd_rec = mem[front][c];
      end
    end
  end

  assign rd_data = fld_sel(rd_rec, rd_field);

endmodule

// File: rtl/enc_snap_ctrl.sv
// Snapshot sequencer for the shared encoder readback mux: walks channels
// 1..NUM_CH into a double-buffered store while yielding the mux to host reads.
module enc_snap_ctrl
  import enc_snap_ctrl_pkg::*;
#(
  parameter int NUM_CH     = NUM_CHANNELS,
  parameter int CHAN_W     = CHAN_WIDTH,
  parameter int STARVE_MAX = STARVE_LIMIT
) (
  input  logic              sysclk,
  input  logic              reset,
  enc_snap_ctrl_if.slave    enc_bus,
  input  logic              snap_trig,
  output logic              snap_busy,
  output logic              snap_done,
  output logic [7:0]        snap_seq,
  output logic              snap_ovr,
  input  logic              ovr_clr,
  input  logic [CHAN_W-1:0] buf_chan,
  input  logic [2:0]        buf_field,
  output logic [31:0]       buf_rdata,
  output logic [1:0]        dbg_state
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [1:0]        state;
  logic [CHAN_W-1:0] snap_chan;
  logic [SC_W-1:0]   starve_cnt;
  logic              force_snap;
  logic              gnt;
  logic              cap_en;
  logic              last_chan;
  enc_rec_t          cap_rec;

  // After STARVE_MAX host-owned CAP cycles the snapshot takes the mux once.
  assign force_snap = (state == ST_CAP) && (starve_cnt == SC_W'(STARVE_MAX));
  assign gnt        = enc_bus.host_rd_req && !force_snap;
  assign cap_en     = (state == ST_CAP) && !gnt;
  assign last_chan  = (snap_chan == CHAN_W'(NUM_CH));

  assign enc_bus.host_rd_gnt  = gnt;
  assign enc_bus.enc_chan_sel = gnt ? enc_bus.host_rd_chan : snap_chan;

  assign cap_rec.quad = enc_bus.enc_quad;
  assign cap_rec.perd = enc_bus.enc_perd;
  assign cap_rec.qtr1 = enc_bus.enc_qtr1;
  assign cap_rec.qtr5 = enc_bus.enc_qtr5;
  assign cap_rec.run  = enc_bus.enc_run;

  assign snap_busy = (state == ST_CAP) || (state == ST_DONE);
  assign snap_done = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      snap_chan  <= CHAN_W'(1);
      starve_cnt <= '0;
      snap_seq   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          starve_cnt <= '0;
          if (snap_trig) begin
            state     <= ST_CAP;
            snap_chan <= CHAN_W'(1);
          end
        end
        ST_CAP: begin
          if (cap_en) begin
            starve_cnt <= '0;
            snap_chan  <= snap_chan + 1'b1;
            if (last_chan) begin
              state <= ST_DONE;
            end
          end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          snap_chan  <= CHAN_W'(1);
          starve_cnt <= '0;
          snap_seq   <= snap_seq + 8'd1;
        end
        default: begin
          state      <= ST_IDLE;
          snap_chan  <= CHAN_W'(1);
          starve_cnt <= '0;
        end
      endcase
    end
  end

  // A trigger that cannot be honoured outranks a same-cycle clear.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      snap_ovr <= 1'b0;
    end else if (snap_trig && (state != ST_IDLE)) begin
      snap_ovr <= 1'b1;
    end else if (ovr_clr) begin
      snap_ovr <= 1'b0;
    end
  end

  enc_snap_bank #(
    .NUM_CH (NUM_CH),
    .CHAN_W (CHAN_W)
  ) u_bank (
    .clk      (sysclk),
    .rst_n    (reset),
    .wr_en    (cap_en),
    .wr_chan  (snap_chan),
    .wr_data  (cap_rec),
    .swap     (state == ST_DONE),
    .rd_chan  (buf_chan),
    .rd_field (buf_field),
    .rd_data  (buf_rdata)
  );

endmodule
